// File: rtl/softmax_argmax.sv
// softmax_argmax: streaming top-2 tracker over one frame of IEEE-754 probabilities.
// Optional macro SOFTMAX_ARGMAX_NAN_EN: skip NaN entries and report them on out_nan.
`default_nettype none

module softmax_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_class,
    output logic [31:0]      out_prob,
    output logic [IDX_W-1:0] out_class2,
    output logic [31:0]      out_prob2
`ifdef SOFTMAX_ARGMAX_NAN_EN
    ,
    output logic             out_nan
`endif
);

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_CLASSES - 1);
`ifdef SOFTMAX_ARGMAX_NAN_EN
    localparam logic [31:0] c_EMPTY = 32'h7FC0_0000;
`else
    localparam logic [31:0] c_EMPTY = 32'h0000_0000;
`endif

    typedef enum logic [0:0] {S_COLLECT = 1'b0, S_HOLD = 1'b1} state_t;

    // Map a float onto an unsigned key whose order is the float total order.
    function automatic logic [31:0] f_key(input logic [31:0] d);
        return d[31] ? ~d : (d ^ 32'h8000_0000);
    endfunction

    state_t             r_state;
    logic [IDX_W-1:0]   r_cnt;
    logic               r_in_ready, r_out_valid;
    logic               r_bvld, r_svld;
    logic [IDX_W-1:0]   r_bcls, r_scls;
    logic [31:0]        r_bdata, r_sdata;
    logic [IDX_W-1:0]   r_out_class, r_out_class2;
    logic [31:0]        r_out_prob, r_out_prob2;
    logic               r_nan, r_out_nan;

    logic               w_beat, w_first, w_ok, w_take_b, w_take_s;
    logic               w_bvld, w_svld;
    logic [31:0]        w_k, w_bkey, w_skey;
    logic               w_n_bvld, w_n_svld, w_n_nan;
    logic [IDX_W-1:0]   w_n_bcls, w_n_scls;
    logic [31:0]        w_n_bdata, w_n_sdata;

    always_comb begin
        w_beat  = in_valid & r_in_ready;
        w_first = (r_cnt == '0);
        w_k     = f_key(in_data);
        // Trackers from the previous frame are ignored on the first beat.
        w_bvld  = r_bvld & ~w_first;
        w_svld  = r_svld & ~w_first;
        w_bkey  = w_bvld ? f_key(r_bdata) : 32'h0;
        w_skey  = w_svld ? f_key(r_sdata) : 32'h0;
`ifdef SOFTMAX_ARGMAX_NAN_EN
        w_ok    = ~((&in_data[30:23]) & (|in_data[22:0]));
        w_n_nan = (r_nan & ~w_first) | ~w_ok;
`else
        w_ok    = 1'b1;
        w_n_nan = 1'b0;
`endif
        w_take_b = w_ok & (~w_bvld | (w_k > w_bkey));
        w_take_s = w_ok & ~w_take_b & (w_k > w_skey);

        w_n_bvld  = w_bvld;
        w_n_bcls  = r_bcls;
        w_n_bdata = r_bdata;
        w_n_svld  = w_svld;
        w_n_scls  = r_scls;
        w_n_sdata = r_sdata;
        if (w_take_b) begin
            w_n_svld  = w_bvld;
            w_n_scls  = r_bcls;
            w_n_sdata = r_bdata;
            w_n_bvld  = 1'b1;
            w_n_bcls  = r_cnt;
            w_n_bdata = in_data;
        end else if (w_take_s) begin
            w_n_svld  = 1'b1;
            w_n_scls  = r_cnt;
            w_n_sdata = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_COLLECT;
            r_cnt        <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_bvld       <= 1'b0;
            r_svld       <= 1'b0;
            r_bcls       <= '0;
            r_scls       <= '0;
            r_bdata      <= '0;
            r_sdata      <= '0;
            r_nan        <= 1'b0;
            r_out_class  <= '0;
            r_out_class2 <= '0;
            r_out_prob   <= '0;
            r_out_prob2  <= '0;
            r_out_nan    <= 1'b0;
        end else if (flush) begin
            r_state      <= S_COLLECT;
            r_cnt        <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_bvld       <= 1'b0;
            r_svld       <= 1'b0;
            r_bcls       <= '0;
            r_scls       <= '0;
            r_bdata      <= '0;
            r_sdata      <= '0;
            r_nan        <= 1'b0;
            r_out_class  <= '0;
            r_out_class2 <= '0;
            r_out_prob   <= '0;
            r_out_prob2  <= '0;
            r_out_nan    <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_beat) begin
                        r_bvld  <= w_n_bvld;
                        r_bcls  <= w_n_bcls;
                        r_bdata <= w_n_bdata;
                        r_svld  <= w_n_svld;
                        r_scls  <= w_n_scls;
                        r_sdata <= w_n_sdata;
                        r_nan   <= w_n_nan;
                        if (r_cnt == c_LAST) begin
                            r_cnt        <= '0;
                            r_state      <= S_HOLD;
                            r_in_ready   <= 1'b0;
                            r_out_valid  <= 1'b1;
                            r_out_class  <= w_n_bvld ? w_n_bcls : '0;
                            r_out_prob   <= w_n_bvld ? w_n_bdata : c_EMPTY;
                            r_out_class2 <= w_n_svld ? w_n_scls : '0;
                            r_out_prob2  <= w_n_svld ? w_n_sdata : c_EMPTY;
                            r_out_nan    <= w_n_nan;
                        end else begin
                            r_cnt <= r_cnt + IDX_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state     <= S_COLLECT;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_class  = r_out_class;
    assign out_prob   = r_out_prob;
    assign out_class2 = r_out_class2;
    assign out_prob2  = r_out_prob2;
`ifdef SOFTMAX_ARGMAX_NAN_EN
    assign out_nan    = r_out_nan;
`else
    logic w_unused;
    assign w_unused = r_out_nan ^ r_nan;
`endif

endmodule

`default_nettype wire

// File: tb/tb_softmax_argmax.sv
// Self-checking bench for softmax_argmax: top-2 reference model plus directed literal cases.
`default_nettype none

module tb_softmax_argmax;
    localparam int N     = 10;
    localparam int IDX_W = 4;
`ifdef SOFTMAX_ARGMAX_NAN_EN
    localparam logic [31:0] EMPTY = 32'h7FC0_0000;
`else
    localparam logic [31:0] EMPTY = 32'h0000_0000;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [IDX_W-1:0] out_class, out_class2;
    logic [31:0]      out_prob, out_prob2;
`ifdef SOFTMAX_ARGMAX_NAN_EN
    logic             out_nan;
`endif

    softmax_argmax #(.NUM_CLASSES(N), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_prob(out_prob),
        .out_class2(out_class2), .out_prob2(out_prob2)
`ifdef SOFTMAX_ARGMAX_NAN_EN
        , .out_nan(out_nan)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [IDX_W-1:0] c1;
        logic [31:0]      p1;
        logic [IDX_W-1:0] c2;
        logic [31:0]      p2;
        logic             nan;
    } res_t;

    function automatic logic [31:0] key(input logic [31:0] d);
        return d[31] ? ~d : (d ^ 32'h8000_0000);
    endfunction

    function automatic bit usable(input logic [31:0] d);
`ifdef SOFTMAX_ARGMAX_NAN_EN
        return !(d[30:23] == 8'hFF && d[22:0] != 0);
`else
        return 1'b1;
`endif
    endfunction

    // Reference: first index of the maximum, then first index of the maximum among the rest.
    function automatic res_t model(input logic [31:0] f[N]);
        res_t r;
        int b = -1;
        int s = -1;
        r.nan = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!usable(f[i])) r.nan = 1'b1;
            else if (b < 0 || key(f[i]) > key(f[b])) b = i;
        end
        for (int i = 0; i < N; i++)
            if (i != b && usable(f[i]) && (s < 0 || key(f[i]) > key(f[s]))) s = i;
        r.c1 = (b < 0) ? '0 : IDX_W'(b);
        r.p1 = (b < 0) ? EMPTY : f[b];
        r.c2 = (s < 0) ? '0 : IDX_W'(s);
        r.p2 = (s < 0) ? EMPTY : f[s];
        return r;
    endfunction

    // Interface-level model: beats accepted in COLLECT fill a frame, a full frame is held.
    logic [31:0] beats[$];
    res_t        exp_q[$];
    bit          hold_m = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            beats.delete();
            exp_q.delete();
            hold_m = 1'b0;
        end else begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, hold_m});
            chk("in_ready", {31'b0, in_ready}, {31'b0, !hold_m});
            if (hold_m) begin
                chk("out_class", {28'b0, out_class}, {28'b0, exp_q[0].c1});
                chk("out_prob", out_prob, exp_q[0].p1);
                chk("out_class2", {28'b0, out_class2}, {28'b0, exp_q[0].c2});
                chk("out_prob2", out_prob2, exp_q[0].p2);
`ifdef SOFTMAX_ARGMAX_NAN_EN
                chk("out_nan", {31'b0, out_nan}, {31'b0, exp_q[0].nan});
`endif
            end
            if (flush) begin
                beats.delete();
                exp_q.delete();
                hold_m = 1'b0;
            end else if (!hold_m && in_valid) begin
                beats.push_back(in_data);
                if (beats.size() == N) begin
                    logic [31:0] f[N];
                    for (int i = 0; i < N; i++) f[i] = beats[i];
                    exp_q.push_back(model(f));
                    beats.delete();
                    hold_m = 1'b1;
                end
            end else if (hold_m && out_ready) begin
                void'(exp_q.pop_front());
                hold_m = 1'b0;
            end
        end
    end

    bit rdy_force_en = 1'b1;
    bit rdy_force    = 1'b1;
    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rdy_force_en ? rdy_force : ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] f[N], input bit gaps);
        for (int i = 0; i < N; i++) begin
            bit acc = 1'b0;
            int t = 0;
            if (gaps)
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    tick();
                end
            in_valid = 1'b1;
            in_data  = f[i];
            while (!acc) begin
                @(negedge clk);
                acc = in_ready;
                tick();
                t++;
                if (t > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout beat=%0d actual=in_ready_low required=accept", i);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout actual=no_out_valid required=out_valid");
        end
    endtask

    function automatic logic [31:0] rnd_word(input logic [31:0] prev);
        logic [31:0] sp[6];
        sp = '{32'h0, 32'h8000_0000, 32'h3F00_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $urandom_range(0, 32'h3F80_0000);
            2: return sp[$urandom_range(0, 5)];
            default: return prev;
        endcase
    endfunction

    logic [31:0] fa[N], fb[N], fc[N], fd[N], fe[N], fr[N];
    res_t        mr;
    int          lat;

    initial begin
        fa = '{32'h3C23_D70A, 32'h3CA3_D70A, 32'h3F66_6666, 32'h3CF5_C28F, 32'h3C23_D70A,
               32'h3C23_D70A, 32'h3BA3_D70A, 32'h3BA3_D70A, 32'h3BA3_D70A, 32'h3BA3_D70A};
        fb = '{default: 32'h0};
        fb[4] = 32'h3F00_0000;
        fb[7] = 32'h3F00_0000;
        fc = '{default: 32'hC000_0000};
        fc[0] = 32'hBF80_0000;
        fc[1] = 32'h8000_0000;
        fc[2] = 32'h0000_0000;
        fd = '{default: 32'h3DCC_CCCD};
        fd[0] = 32'h3E4C_CCCD;
        fd[9] = 32'h3E80_0000;
        fe = '{default: 32'h3DCC_CCCD};
        fe[0] = 32'h7FC0_0000;
        fe[5] = 32'h3F33_3333;

        // The reference model itself, against hand-derived answers.
        mr = model(fa);
        chk("model_a_class", {28'b0, mr.c1}, 32'd2);
        chk("model_a_class2", {28'b0, mr.c2}, 32'd3);
        mr = model(fc);
        chk("model_sign_class", {28'b0, mr.c1}, 32'd2);
        chk("model_sign_class2", {28'b0, mr.c2}, 32'd1);

        repeat (2) @(posedge clk);
        #2;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_class", {28'b0, out_class}, 32'd0);
        chk("rst_out_prob", out_prob, 32'd0);
        chk("rst_out_class2", {28'b0, out_class2}, 32'd0);
        chk("rst_out_prob2", out_prob2, 32'd0);
`ifdef SOFTMAX_ARGMAX_NAN_EN
        chk("rst_out_nan", {31'b0, out_nan}, 32'd0);
`endif
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // Reference frame held under backpressure, then a second frame queued behind it.
        rdy_force = 1'b0;
        send_frame(fa, 1'b0);
        wait_result(lat);
        chk("latency", lat, 32'd1);
        chk("a_class", {28'b0, out_class}, 32'd2);
        chk("a_prob", out_prob, 32'h3F66_6666);
        chk("a_class2", {28'b0, out_class2}, 32'd3);
        chk("a_prob2", out_prob2, 32'h3CF5_C28F);
        tick();
        fork
            send_frame(fb, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
                    chk("bp_class", {28'b0, out_class}, 32'd2);
                end
                tick();
                rdy_force = 1'b1;
            end
        join
        rdy_force = 1'b0;
        wait_result(lat);
        chk("tie_class", {28'b0, out_class}, 32'd4);
        chk("tie_class2", {28'b0, out_class2}, 32'd7);
        tick();
        rdy_force = 1'b1;
        repeat (2) tick();

        rdy_force = 1'b0;
        send_frame(fc, 1'b0);
        wait_result(lat);
        chk("sign_class", {28'b0, out_class}, 32'd2);
        chk("sign_class2", {28'b0, out_class2}, 32'd1);
        tick();
        rdy_force = 1'b1;
        repeat (2) tick();

        // Flush coincident with beat 6 of a partial frame, then a clean frame.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 2) ? 32'h3F7F_FFFF : 32'h3F00_0000;
            tick();
        end
        in_data = 32'h3F7F_FFFF;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        rdy_force = 1'b0;
        send_frame(fd, 1'b0);
        wait_result(lat);
        chk("flush_class", {28'b0, out_class}, 32'd9);
        chk("flush_class2", {28'b0, out_class2}, 32'd0);
        tick();
        rdy_force = 1'b1;
        repeat (2) tick();

        rdy_force = 1'b0;
        send_frame(fe, 1'b0);
        wait_result(lat);
`ifdef SOFTMAX_ARGMAX_NAN_EN
        chk("nan_class", {28'b0, out_class}, 32'd5);
        chk("nan_flag", {31'b0, out_nan}, 32'd1);
`else
        chk("nan_class", {28'b0, out_class}, 32'd0);
`endif
        tick();
        rdy_force = 1'b1;
        repeat (2) tick();
`ifdef SOFTMAX_ARGMAX_NAN_EN
        fr = '{default: 32'h7FC0_0001};
        rdy_force = 1'b0;
        send_frame(fr, 1'b0);
        wait_result(lat);
        chk("allnan_class", {28'b0, out_class}, 32'd0);
        chk("allnan_prob", out_prob, 32'h7FC0_0000);
        chk("allnan_prob2", out_prob2, 32'h7FC0_0000);
        tick();
        rdy_force = 1'b1;
        repeat (2) tick();
`endif

        // Asynchronous reset while a result is held, then in the middle of a frame.
        rdy_force = 1'b0;
        send_frame(fa, 1'b0);
        wait_result(lat);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_out_class", {28'b0, out_class}, 32'd0);
        chk("arst_out_prob", out_prob, 32'd0);
        tick();
        rst_n = 1'b1;
        rdy_force = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h3F7F_FFFF;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        rdy_force = 1'b0;
        send_frame(fd, 1'b0);
        wait_result(lat);
        chk("post_rst_class", {28'b0, out_class}, 32'd9);
        tick();

        // Randomized frames with input gaps and random output backpressure.
        rdy_force_en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            logic [31:0] prev = 32'h3E00_0000;
            for (int i = 0; i < N; i++) begin
                fr[i] = rnd_word(prev);
                prev  = fr[i];
            end
            send_frame(fr, 1'b1);
        end
        rdy_force_en = 1'b1;
        rdy_force    = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/softmax_argmax.md
# softmax_argmax

Streaming classifier back-end that sits directly downstream of the softmax IEEE-754 divider. It accepts the NUM_CLASSES normalized probabilities of one inference as single-precision words, one per handshake, and tracks the best and second-best entries. After the last entry it presents the winning class index and probability, plus the runner-up, on a valid/ready output.

## Interface
- NUM_CLASSES, default 10: entries per frame (≥2).
- IDX_W, default 4: index width, must satisfy 2^IDX_W ≥ NUM_CLASSES.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- flush  in  1  synchronous abort; drops partial frame and any held result.
- in_valid  in  1  probability word present.
- in_ready  out  1  block can accept a word.
- in_data  in  32  IEEE-754 single-precision probability.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_class  out  IDX_W  index of maximum entry.
- out_prob  out  32  value of maximum entry.
- out_class2  out  IDX_W  index of second-largest entry.
- out_prob2  out  32  value of second-largest entry.
- out_nan  out  1  present only with SOFTMAX_ARGMAX_NAN_EN; any NaN seen in frame.

## Operation
- States: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
- Beat accepted when in_valid & in_ready; entry index = beat counter cnt (0..NUM_CLASSES-1).
- Ordering key: sign=0 → key = data ^ 32'h8000_0000; sign=1 → key = ~data; compare keys unsigned. Gives total order −Inf < negatives < −0 < +0 < positives < +Inf.
- Update on accepted beat with key k:
  - k > best_key: second ← best; best ← (cnt, data).
  - else k > second_key: second ← (cnt, data).
  - else no change. Strict compares: on ties, the lowest index wins.
- At cnt=0, the entry unconditionally loads best, and second is invalidated. Second's key is treated as minimum until it is loaded.
- On the beat with cnt=NUM_CLASSES-1: the result registers take the post-update values, cnt wraps to 0, and the state goes to HOLD.
- HOLD: outputs stable until out_valid & out_ready. Then the state returns to COLLECT.
- flush: in any state, go to COLLECT, cnt←0, out_valid←0, and clear the trackers. flush wins over a simultaneous in or out handshake.

## Timing
- Reset values: in_ready=1, out_valid=0, out_class=0, out_class2=0, out_prob=0, out_prob2=0, out_nan=0. State COLLECT, cnt=0.
- Throughput: one entry per cycle with no bubbles inside a frame.
- Latency: out_valid rises on the first clock edge after the last beat is accepted, so it is visible the cycle after.
- Back-to-back frames: in_ready deasserts in HOLD. It returns to 1 in the cycle after the out handshake, so minimum frame spacing is NUM_CLASSES+1 cycles.
- in_ready and out_valid come from registers only, with no combinational path from in_valid or out_ready.
- Reset asserted mid-frame: all state is cleared immediately and the partial frame is discarded.

## Configuration
- SOFTMAX_ARGMAX_NAN_EN defined:
  - NaN entries (exp=0xFF, mantissa≠0) do not update best or second, and they set the out_nan sticky for the frame.
  - If every entry is NaN, the result is class 0 with prob 32'h7FC0_0000 for both best and second.
- Not defined:
  - No out_nan port.
  - NaN is ranked by its raw key, so +NaN outranks +Inf.

## Test plan
- Frame {0.01,0.02,0.9,0.03,0.01,0.01,0.005,0.005,0.005,0.005} with out_ready=1 → out_class=2, out_prob=0x3F66_6666, out_class2=3, out_prob2=0x3CF5_C28F, out_valid one cycle after the 10th beat.
- Tie: 0.5 at indices 4 and 7, others 0.0 → out_class=4, out_class2=7.
- Backpressure: out_ready=0 for 5 cycles, then a second frame offered → in_ready=0 and outputs stable throughout. The second frame is accepted only after the out handshake, with no lost beats.
- Signs: {−1.0, −0.0, +0.0, …rest −2.0} → out_class=2, out_class2=1.
- flush asserted at beat 6, then a full new frame → the result reflects only the new frame. rst_n pulsed mid-frame → reset values observed asynchronously.
- NaN with SOFTMAX_ARGMAX_NAN_EN: 0x7FC0_0000 at index 0, 0.7 at index 5 → out_class=5, out_nan=1. Without the macro → out_class=0.
